// File: rtl/ft_device_emu_if.sv
// Local-side bundle of ft_device_emu: the to-host source port, the from-host
// sink port, sticky error / word-count status and the FSM state for debug.
//
// Handshake: src_valid pushes src_data/src_be on a clock edge when src_full
// is 0; a push while src_full is 1 is dropped and flagged. sink_data/sink_be
// show the from-host head (first-word fall-through) whenever sink_empty is 0,
// and sink_get consumes it on the edge; sink_get while empty is ignored.
interface ft_device_emu_if #(
  parameter int BUS_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]   src_data;
  logic [BUS_WIDTH/8-1:0] src_be;
  logic                   src_valid;
  logic                   src_full;
  logic [BUS_WIDTH-1:0]   sink_data;
  logic [BUS_WIDTH/8-1:0] sink_be;
  logic                   sink_empty;
  logic                   sink_get;
  logic [3:0]             err_flags;
  logic                   err_clr;
  logic [31:0]            toh_words;
  logic [31:0]            frh_words;
  logic [1:0]             state_dbg;

  modport slave (
    input  src_data, src_be, src_valid, sink_get, err_clr,
    output src_full, sink_data, sink_be, sink_empty, err_flags,
           toh_words, frh_words, state_dbg
  );

  modport master (
    output src_data, src_be, src_valid, sink_get, err_clr,
    input  src_full, sink_data, sink_be, sink_empty, err_flags,
           toh_words, frh_words, state_dbg
  );
endinterface

// File: rtl/ft_device_emu.sv
// Chip-side emulation of an FT600/FT601 245-style synchronous FIFO bus.
// Two FIFOs (to-host, from-host), registered ft_rxf/ft_txe flags, bus
// protocol checker with sticky error flags and transfer word counters.
// Optional macro FT_EMU_STALL_EN adds an LFSR that randomly forces the
// flags high to throttle the master, exposed on stall_status.
module ft_device_emu #(
  parameter int          BUS_WIDTH = 16,
  parameter int          TOH_DEPTH = 1024,
  parameter int          FRH_DEPTH = 1024,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ft_rxf,
  output logic                   ft_txe,
  inout  wire  [BUS_WIDTH-1:0]   ft_data,
  inout  wire  [BUS_WIDTH/8-1:0] ft_be,
  input  logic                   ft_rd,
  input  logic                   ft_wr,
  input  logic                   ft_oe,
`ifdef FT_EMU_STALL_EN
  output logic [1:0]             stall_status,
`endif
  ft_device_emu_if.slave         lif
);
  localparam int BE_W = BUS_WIDTH / 8;
  localparam int W    = BUS_WIDTH + BE_W;  // stored word is {be, data}
  localparam int TAW  = $clog2(TOH_DEPTH);
  localparam int FAW  = $clog2(FRH_DEPTH);
  localparam int TCW  = TAW + 1;
  localparam int FCW  = FAW + 1;

  if (BUS_WIDTH != 16 && BUS_WIDTH != 32) begin : g_bad_width
    $fatal(1, "ft_device_emu: BUS_WIDTH must be 16 or 32");
  end
  if ((TOH_DEPTH & (TOH_DEPTH - 1)) != 0 || (FRH_DEPTH & (FRH_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ft_device_emu: FIFO depths must be powers of two");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $fatal(1, "ft_device_emu: LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_READ, S_WRITE} state_t;
  state_t state, state_next;

  logic [W-1:0]   toh_mem [TOH_DEPTH];
  logic [TAW-1:0] toh_wp, toh_rp;
  logic [TCW-1:0] toh_count, toh_count_next;
  logic [W-1:0]   frh_mem [FRH_DEPTH];
  logic [FAW-1:0] frh_wp, frh_rp;
  logic [FCW-1:0] frh_count, frh_count_next;

  logic         toh_push, toh_pop, frh_push, frh_pop;
  logic         src_full, sink_empty, bus_drive;
  logic [W-1:0] toh_head, frh_head;
  logic [3:0]   err_new, err_flags;
  logic [31:0]  toh_words, frh_words;
  logic [1:0]   stall;

  assign toh_head   = toh_mem[toh_rp];
  assign frh_head   = frh_mem[frh_rp];
  assign src_full   = (toh_count == TCW'(TOH_DEPTH));
  assign sink_empty = (frh_count == '0);

  // The bus follows ft_oe combinationally so the head is already valid on
  // the first oe-low cycle; reset releases it immediately.
  assign bus_drive = !ft_oe && !rst;
  assign ft_data   = bus_drive ? toh_head[BUS_WIDTH-1:0] : 'z;
  assign ft_be     = bus_drive ? toh_head[W-1:BUS_WIDTH] : 'z;

  // Transfers are granted against the registered flags, so a pop or capture
  // can never hit an empty or full FIFO. Any protocol error blocks them.
  assign toh_push = lif.src_valid && !src_full;
  assign toh_pop  = (state == S_TURN || state == S_READ) && !ft_oe && !ft_rd
                    && ft_wr && !ft_rxf;
  assign frh_push = !ft_wr && ft_oe && ft_rd && !ft_txe;
  assign frh_pop  = lif.sink_get && !sink_empty;

  // Protocol checker and local overflow detection.
  always_comb begin
    err_new    = '0;
    err_new[0] = !ft_rd && (ft_oe || state == S_IDLE || state == S_WRITE);
    err_new[1] = !ft_wr && !ft_oe;
    err_new[2] = !ft_rd && !ft_wr;
    err_new[3] = lif.src_valid && src_full;
  end

  // Bus FSM next-state: tracks turnaround so a read is only legal after one
  // full oe-low cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!ft_oe) state_next = S_TURN;
               else if (!ft_wr) state_next = S_WRITE;
      S_TURN:  if (ft_oe) state_next = S_IDLE;
               else if (!ft_rd) state_next = S_READ;
      S_READ:  if (ft_oe) state_next = S_IDLE;
               else if (ft_rd) state_next = S_TURN;
      S_WRITE: if (ft_wr) state_next = ft_oe ? S_IDLE : S_TURN;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Occupancy of both FIFOs after this edge; drives the flag registers.
  always_comb begin
    toh_count_next = toh_count;
    frh_count_next = frh_count;
    if (toh_push && !toh_pop)      toh_count_next = toh_count + TCW'(1);
    else if (!toh_push && toh_pop) toh_count_next = toh_count - TCW'(1);
    if (frh_push && !frh_pop)      frh_count_next = frh_count + FCW'(1);
    else if (!frh_push && frh_pop) frh_count_next = frh_count - FCW'(1);
  end

  // FIFO storage writes; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (toh_push) toh_mem[toh_wp] <= {lif.src_be, lif.src_data};
    if (frh_push) frh_mem[frh_wp] <= {ft_be, ft_data};
  end

  // FIFO pointers and counts; reset flushes both FIFOs at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toh_wp    <= '0;
      toh_rp    <= '0;
      toh_count <= '0;
      frh_wp    <= '0;
      frh_rp    <= '0;
      frh_count <= '0;
    end else begin
      if (toh_push) toh_wp <= toh_wp + TAW'(1);
      if (toh_pop)  toh_rp <= toh_rp + TAW'(1);
      if (frh_push) frh_wp <= frh_wp + FAW'(1);
      if (frh_pop)  frh_rp <= frh_rp + FAW'(1);
      toh_count <= toh_count_next;
      frh_count <= frh_count_next;
    end
  end

  // Registered bus flags from next-cycle occupancy, optionally stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ft_rxf <= 1'b1;
      ft_txe <= 1'b1;
    end else begin
      ft_rxf <= (toh_count_next == '0) | stall[0];
      ft_txe <= (frh_count_next == FCW'(FRH_DEPTH)) | stall[1];
    end
  end

  // Sticky errors (a new error in the clear cycle survives) and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flags <= '0;
      toh_words <= '0;
      frh_words <= '0;
    end else begin
      err_flags <= lif.err_clr ? err_new : (err_flags | err_new);
      if (toh_pop)  toh_words <= toh_words + 32'd1;
      if (frh_push) frh_words <= frh_words + 32'd1;
    end
  end

`ifdef FT_EMU_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign stall        = lfsr[1:0];
  assign stall_status = stall;

  // Fibonacci LFSR, taps 16/14/13/11, advancing every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign stall = 2'b00;
`endif

  assign lif.src_full   = src_full;
  assign lif.sink_data  = frh_head[BUS_WIDTH-1:0];
  assign lif.sink_be    = frh_head[W-1:BUS_WIDTH];
  assign lif.sink_empty = sink_empty;
  assign lif.err_flags  = err_flags;
  assign lif.toh_words  = toh_words;
  assign lif.frh_words  = frh_words;
  assign lif.state_dbg  = state;
endmodule

// File: tb/tb_ft_device_emu.sv
// Directed testbench for ft_device_emu: a behavioural bus master plus local
// source/sink drivers, with expected-word queues for both directions.
`timescale 1ns/1ps
module tb_ft_device_emu;
  localparam int BW    = 16;
  localparam int TOH_D = 1024;
  localparam int FRH_D = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic ft_rd, ft_wr, ft_oe;
  logic ft_rxf, ft_txe;
  wire  [BW-1:0] ft_data;
  wire  [1:0]    ft_be;
  logic          m_drv;
  logic [BW-1:0] m_data;
  logic [1:0]    m_be;
  assign ft_data = m_drv ? m_data : 'z;
  assign ft_be   = m_drv ? m_be : 'z;

  ft_device_emu_if #(.BUS_WIDTH(BW)) lif ();

`ifdef FT_EMU_STALL_EN
  logic [1:0] stall_status;
  int         stall_seen = 0;
  always @(negedge clk) if (!rst && stall_status != 2'b00) stall_seen++;
`endif

  ft_device_emu #(.BUS_WIDTH(BW), .TOH_DEPTH(TOH_D), .FRH_DEPTH(FRH_D)) dut (
    .clk(clk), .rst(rst), .ft_rxf(ft_rxf), .ft_txe(ft_txe),
    .ft_data(ft_data), .ft_be(ft_be), .ft_rd(ft_rd), .ft_wr(ft_wr), .ft_oe(ft_oe),
`ifdef FT_EMU_STALL_EN
    .stall_status(stall_status),
`endif
    .lif(lif)
  );

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [17:0] toh_exp_q[$];
  logic [17:0] frh_exp_q[$];
  int          toh_occ = 0;
  logic [31:0] exp_toh_words = 0;
  logic [31:0] exp_frh_words = 0;
  logic [15:0] wr_buf [0:511];
  logic [15:0] rd_buf [0:511];

  // Driver: push n words base+i on the local source side.
  task automatic push_words(input logic [15:0] base, input int n, input logic [1:0] be);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lif.src_valid = 1'b1;
      lif.src_data  = base + 16'(i);
      lif.src_be    = be;
      if (toh_occ < TOH_D) begin
        toh_exp_q.push_back({be, base + 16'(i)});
        toh_occ++;
      end
    end
    @(negedge clk);
    lif.src_valid = 1'b0;
  endtask

  // Driver: master read of n words; leaves oe low, rd high on return.
  task automatic master_read(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    logic [17:0] exp_w;
    @(negedge clk);
    ft_oe = 1'b0;
    ft_rd = 1'b1;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!ft_rxf) begin
        checks++;
        if (toh_exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_word: got %h expected no word", {ft_be, ft_data});
        end else begin
          exp_w = toh_exp_q.pop_front();
          toh_occ--;
          if ({ft_be, ft_data} !== exp_w) begin
            errors++;
            $display("FAIL read_word[%0d]: got %h expected %h", got, {ft_be, ft_data}, exp_w);
          end
        end
        rd_buf[got] = ft_data;
        ft_rd = 1'b0;
        got++;
        exp_toh_words++;
      end else begin
        ft_rd = 1'b1;
      end
    end
    @(negedge clk);
    ft_rd = 1'b1;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL read_count: got %0d expected %0d", got, n);
    end
  endtask

  task automatic bus_idle();
    ft_oe = 1'b1;
    ft_rd = 1'b1;
    ft_wr = 1'b1;
    m_drv = 1'b0;
    @(negedge clk);
  endtask

  // Driver: master write of wr_buf[start..], optionally draining the sink.
  task automatic master_write(input int start, input int n, input logic [1:0] be,
                              input bit drain, input int budget, output int sent);
    int cyc = 0;
    sent = 0;
    while (cyc < budget && (sent < n || (drain && frh_exp_q.size() != 0))) begin
      @(negedge clk);
      cyc++;
      lif.sink_get = 1'b0;
      if (drain && !lif.sink_empty) begin
        checks++;
        if (frh_exp_q.size() == 0) begin
          errors++;
          $display("FAIL sink_word: got %h expected no word", {lif.sink_be, lif.sink_data});
        end else if ({lif.sink_be, lif.sink_data} !== frh_exp_q[0]) begin
          errors++;
          $display("FAIL sink_word: got %h expected %h", {lif.sink_be, lif.sink_data}, frh_exp_q[0]);
        end
        if (frh_exp_q.size() != 0) void'(frh_exp_q.pop_front());
        lif.sink_get = 1'b1;
      end
      if (!ft_txe && sent < n) begin
        ft_wr  = 1'b0;
        m_drv  = 1'b1;
        m_data = wr_buf[start + sent];
        m_be   = be;
        frh_exp_q.push_back({be, wr_buf[start + sent]});
        sent++;
        exp_frh_words++;
      end else begin
        ft_wr = 1'b1;
        m_drv = 1'b0;
      end
    end
    @(negedge clk);
    ft_wr = 1'b1;
    m_drv = 1'b0;
    lif.sink_get = 1'b0;
  endtask

  // Driver: one local sink_get with head check.
  task automatic sink_pop();
    @(negedge clk);
    checks++;
    if (frh_exp_q.size() == 0 || {lif.sink_be, lif.sink_data} !== frh_exp_q[0]) begin
      errors++;
      $display("FAIL sink_pop: got %h expected %h", {lif.sink_be, lif.sink_data},
               (frh_exp_q.size() != 0) ? frh_exp_q[0] : 18'h0);
    end
    if (frh_exp_q.size() != 0) void'(frh_exp_q.pop_front());
    lif.sink_get = 1'b1;
    @(negedge clk);
    lif.sink_get = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ft_rd = 1'b1; ft_wr = 1'b1; ft_oe = 1'b1; m_drv = 1'b0; m_data = '0; m_be = '0;
    lif.src_valid = 1'b0; lif.src_data = '0; lif.src_be = '0;
    lif.sink_get = 1'b0; lif.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ft_rxf !== 1'b1) begin errors++; $display("FAIL rst_rxf: got %b expected 1", ft_rxf); end
    checks++; if (ft_txe !== 1'b1) begin errors++; $display("FAIL rst_txe: got %b expected 1", ft_txe); end
    checks++; if (lif.src_full !== 1'b0) begin errors++; $display("FAIL rst_src_full: got %b expected 0", lif.src_full); end
    checks++; if (lif.sink_empty !== 1'b1) begin errors++; $display("FAIL rst_sink_empty: got %b expected 1", lif.sink_empty); end
    checks++; if (lif.err_flags !== 4'h0) begin errors++; $display("FAIL rst_err: got %h expected 0", lif.err_flags); end
    checks++; if (lif.toh_words !== 32'd0 || lif.frh_words !== 32'd0) begin
      errors++; $display("FAIL rst_words: got %0d/%0d expected 0/0", lif.toh_words, lif.frh_words); end
    checks++; if (lif.state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", lif.state_dbg); end
    rst = 1'b0;
    @(negedge clk);
`ifndef FT_EMU_STALL_EN
    checks++; if (ft_txe !== 1'b0) begin errors++; $display("FAIL post_rst_txe: got %b expected 0", ft_txe); end
`endif
    checks++; if (ft_rxf !== 1'b1) begin errors++; $display("FAIL post_rst_rxf: got %b expected 1", ft_rxf); end
  endtask

  task automatic test_read();
    push_words(16'h1000, 8, 2'b11);
    master_read(8, 40);
    checks++; if (ft_rxf !== 1'b1) begin errors++; $display("FAIL read_rxf_after_last: got %b expected 1", ft_rxf); end
    bus_idle();
    checks++; if (lif.toh_words !== 32'd8) begin errors++; $display("FAIL read_toh_words: got %0d expected 8", lif.toh_words); end
    checks++; if (lif.err_flags !== 4'h0) begin errors++; $display("FAIL read_err: got %h expected 0", lif.err_flags); end
    checks++; if (lif.state_dbg !== 2'd0) begin errors++; $display("FAIL read_state: got %0d expected 0", lif.state_dbg); end
  endtask

  task automatic test_write();
    int sent;
    for (int i = 0; i < 5; i++) wr_buf[i] = 16'hA5A0 + 16'(i);
    master_write(0, 5, 2'b11, 1'b1, 40, sent);
    checks++; if (sent != 5) begin errors++; $display("FAIL write_sent: got %0d expected 5", sent); end
    checks++; if (lif.sink_empty !== 1'b1) begin errors++; $display("FAIL write_sink_empty: got %b expected 1", lif.sink_empty); end
    checks++; if (lif.frh_words !== exp_frh_words) begin errors++; $display("FAIL write_frh_words: got %0d expected %0d", lif.frh_words, exp_frh_words); end
    wr_buf[0] = 16'h7E57;
    master_write(0, 1, 2'b00, 1'b1, 10, sent);
    checks++; if (sent != 1) begin errors++; $display("FAIL write_be0_sent: got %0d expected 1", sent); end
  endtask

  task automatic test_full();
    int sent;
    for (int i = 0; i < 6; i++) wr_buf[i] = 16'hB000 + 16'(i);
    master_write(0, 6, 2'b11, 1'b0, 20, sent);
    checks++; if (sent != 4) begin errors++; $display("FAIL full_sent: got %0d expected 4", sent); end
    checks++; if (ft_txe !== 1'b1) begin errors++; $display("FAIL full_txe: got %b expected 1", ft_txe); end
    checks++; if (lif.frh_words !== exp_frh_words) begin errors++; $display("FAIL full_frh_words: got %0d expected %0d", lif.frh_words, exp_frh_words); end
    sink_pop();
    sink_pop();
    master_write(4, 2, 2'b11, 1'b0, 20, sent);
    checks++; if (sent != 2) begin errors++; $display("FAIL full_resume_sent: got %0d expected 2", sent); end
    checks++; if (ft_txe !== 1'b1) begin errors++; $display("FAIL full_txe_again: got %b expected 1", ft_txe); end
    repeat (4) sink_pop();
    checks++; if (lif.sink_empty !== 1'b1 || ft_txe !== 1'b0) begin
      errors++; $display("FAIL full_drained: got empty=%b txe=%b expected 1/0", lif.sink_empty, ft_txe); end
  endtask

  task automatic test_protocol();
    push_words(16'h3000, 1, 2'b11);
    checks++; if (ft_rxf !== 1'b0) begin errors++; $display("FAIL proto_rxf: got %b expected 0", ft_rxf); end
    ft_rd = 1'b0;
    @(negedge clk); ft_rd = 1'b1;
    checks++; if (lif.err_flags !== 4'b0001) begin errors++; $display("FAIL rd_no_turn: got %b expected 0001", lif.err_flags); end
    checks++; if (ft_rxf !== 1'b0 || lif.toh_words !== exp_toh_words) begin
      errors++; $display("FAIL rd_no_turn_nopop: got rxf=%b words=%0d expected 0/%0d", ft_rxf, lif.toh_words, exp_toh_words); end
    lif.err_clr = 1'b1;
    @(negedge clk); lif.err_clr = 1'b0;
    checks++; if (lif.err_flags !== 4'b0000) begin errors++; $display("FAIL err_clr: got %b expected 0000", lif.err_flags); end
    ft_oe = 1'b0; ft_wr = 1'b0;
    @(negedge clk); ft_oe = 1'b1; ft_wr = 1'b1;
    checks++; if (lif.err_flags !== 4'b0010) begin errors++; $display("FAIL wr_during_oe: got %b expected 0010", lif.err_flags); end
    checks++; if (lif.sink_empty !== 1'b1 || lif.frh_words !== exp_frh_words || ft_rxf !== 1'b0) begin
      errors++; $display("FAIL wr_during_oe_nocap: got empty=%b words=%0d rxf=%b", lif.sink_empty, lif.frh_words, ft_rxf); end
    @(negedge clk);
    lif.err_clr = 1'b1; ft_rd = 1'b0;
    @(negedge clk); lif.err_clr = 1'b0; ft_rd = 1'b1;
    checks++; if (lif.err_flags !== 4'b0001) begin errors++; $display("FAIL clr_vs_new: got %b expected 0001", lif.err_flags); end
    lif.err_clr = 1'b1; ft_rd = 1'b0; ft_wr = 1'b0; m_drv = 1'b1; m_data = 16'hDEAD; m_be = 2'b11;
    @(negedge clk); lif.err_clr = 1'b0; ft_rd = 1'b1; ft_wr = 1'b1; m_drv = 1'b0;
    checks++; if (lif.err_flags !== 4'b0101) begin errors++; $display("FAIL rd_and_wr: got %b expected 0101", lif.err_flags); end
    checks++; if (lif.sink_empty !== 1'b1 || lif.frh_words !== exp_frh_words) begin
      errors++; $display("FAIL rd_and_wr_nocap: got empty=%b words=%0d", lif.sink_empty, lif.frh_words); end
    lif.err_clr = 1'b1;
    @(negedge clk); lif.err_clr = 1'b0;
    @(negedge clk);
    checks++; if (lif.err_flags !== 4'b0000 || lif.state_dbg !== 2'd0) begin
      errors++; $display("FAIL proto_end: got err=%b state=%0d expected 0000/0", lif.err_flags, lif.state_dbg); end
  endtask

  task automatic test_overflow_reset();
    push_words(16'h2000, TOH_D - 1, 2'b11);
    checks++; if (lif.src_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", lif.src_full); end
    push_words(16'hDEAD, 1, 2'b11);
    checks++; if (lif.err_flags !== 4'b1000) begin errors++; $display("FAIL src_overflow: got %b expected 1000", lif.err_flags); end
    master_read(3, 20);
    ft_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1; m_drv = 1'b1; m_data = 16'h5A5A; m_be = 2'b01;
    #1;
    checks++; if (ft_rxf !== 1'b1 || lif.src_full !== 1'b0 || lif.sink_empty !== 1'b1) begin
      errors++; $display("FAIL rst_mid_read: got rxf=%b full=%b empty=%b expected 1/0/1", ft_rxf, lif.src_full, lif.sink_empty); end
    checks++; if (ft_data !== 16'h5A5A || ft_be !== 2'b01) begin
      errors++; $display("FAIL rst_bus_release: got %h/%b expected 5a5a/01", ft_data, ft_be); end
    checks++; if (lif.toh_words !== 32'd0 || lif.err_flags !== 4'h0 || lif.state_dbg !== 2'd0) begin
      errors++; $display("FAIL rst_mid_state: got words=%0d err=%b state=%0d", lif.toh_words, lif.err_flags, lif.state_dbg); end
    ft_oe = 1'b1; ft_rd = 1'b1; m_drv = 1'b0;
    toh_exp_q.delete(); frh_exp_q.delete(); toh_occ = 0;
    exp_toh_words = 0; exp_frh_words = 0;
    @(negedge clk); rst = 1'b0;
    push_words(16'h4000, 2, 2'b10);
    master_read(2, 20);
    bus_idle();
    checks++; if (lif.toh_words !== 32'd2) begin errors++; $display("FAIL post_rst_words: got %0d expected 2", lif.toh_words); end
  endtask

`ifdef FT_EMU_STALL_EN
  task automatic test_stall_loopback();
    int sent;
    push_words(16'h6000, 512, 2'b11);
    master_read(512, 8000);
    bus_idle();
    for (int i = 0; i < 512; i++) wr_buf[i] = rd_buf[i];
    master_write(0, 512, 2'b11, 1'b1, 8000, sent);
    checks++; if (sent != 512) begin errors++; $display("FAIL stall_sent: got %0d expected 512", sent); end
    checks++; if (lif.toh_words !== 32'd512 || lif.frh_words !== 32'd512) begin
      errors++; $display("FAIL stall_words: got %0d/%0d expected 512/512", lif.toh_words, lif.frh_words); end
    checks++; if (stall_seen == 0) begin errors++; $display("FAIL stall_seen: got 0 expected >0"); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FT_EMU_STALL_EN
    test_stall_loopback();
`else
    test_read();
    test_write();
    test_full();
    test_protocol();
    test_overflow_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
